// File: rtl/scan_chain_driver.sv
// scan_chain_driver
// Tester-side initiator for one full-scan chain. It loads pseudo-random
// patterns from a 16-bit Fibonacci LFSR and sequences scan_en through the
// load, capture and unload phases. Responses returning on scan_out are folded
// into a 16-bit serial MISR, and the MISR is compared against GOLDEN at the
// end of the run.
//
// Phase sequence for one run:
//   LOAD (CHAIN_LEN) -> { CAPTURE (1) -> SHIFT (CHAIN_LEN) } x (NUM_PAT-1)
//   -> CAPTURE (1) -> UNLOAD (CHAIN_LEN) -> DONE
//
// Every output comes straight from a flop, so scan_in and scan_en are
// glitch-free for the whole cycle.

module scan_chain_driver #(
    parameter int          CHAIN_LEN = 228,
    parameter int          NUM_PAT   = 64,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic        scan_out,
    output logic        scan_in,
    output logic        scan_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic        pass
);

    // Counter widths are sized so that no wrap can occur within a run.
    localparam int SC_W = $clog2(CHAIN_LEN + 1);
    localparam int PC_W = $clog2(NUM_PAT + 1);

    // Terminal counts: the last shift cycle of a phase and the last pattern.
    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PAT_LAST   = PC_W'(NUM_PAT - 1);

    // FSM encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Feedback parity of the x^16+x^14+x^13+x^11+1 taps (LFSR and MISR share it).
    function automatic logic tap_parity(input logic [15:0] v);
        tap_parity = v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    // One step of the pattern generator.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[14:0], tap_parity(v)};
    endfunction

    // One step of the serial signature register with the response bit folded in.
    function automatic logic [15:0] misr_step(input logic [15:0] v, input logic b);
        misr_step = {v[14:0], tap_parity(v) ^ b};
    endfunction

    // Registered state.
    logic [2:0]      state_r;
    logic [SC_W-1:0] shift_cnt_r;
    logic [PC_W-1:0] pat_cnt_r;
    logic [15:0]     lfsr_r;
    logic [15:0]     misr_r;
    logic            scan_in_r;
    logic            scan_en_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;

    // Next-state values.
    logic [2:0]      state_s;
    logic [SC_W-1:0] shift_cnt_s;
    logic [PC_W-1:0] pat_cnt_s;
    logic [15:0]     lfsr_s;
    logic [15:0]     misr_s;
    logic            scan_in_s;
    logic            scan_en_s;
    logic            busy_s;
    logic            done_s;
    logic            pass_s;

    // Helpers shared by several FSM branches.
    logic [15:0]     lfsr_adv_s;
    logic [15:0]     misr_adv_s;
    logic            last_bit_s;

    // Precompute the advanced LFSR/MISR values and the end-of-phase flag.
    always_comb begin
        lfsr_adv_s = lfsr_step(lfsr_r);
        misr_adv_s = misr_step(misr_r, scan_out);
        last_bit_s = (shift_cnt_r == SHIFT_LAST);
    end

    // Sequencer: next state plus the next values of every registered output.
    // Outputs are computed one cycle ahead, so each flop holds the value that
    // belongs to the state being entered.
    always_comb begin
        state_s     = state_r;
        shift_cnt_s = shift_cnt_r;
        pat_cnt_s   = pat_cnt_r;
        lfsr_s      = lfsr_r;
        misr_s      = misr_r;
        scan_in_s   = 1'b0;
        scan_en_s   = 1'b0;
        busy_s      = 1'b0;
        done_s      = done_r;
        pass_s      = pass_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Fresh run. The first stimulus bit is the seed LSB, and it
                    // is already on scan_in in the first LOAD cycle.
                    state_s     = ST_LOAD;
                    shift_cnt_s = {SC_W{1'b0}};
                    pat_cnt_s   = {PC_W{1'b0}};
                    lfsr_s      = SEED;
                    misr_s      = 16'h0000;
                    scan_in_s   = SEED[0];
                    scan_en_s   = 1'b1;
                    busy_s      = 1'b1;
                    done_s      = 1'b0;
                    pass_s      = 1'b0;
                end else begin
                    // Hold: done, pass and signature keep their values.
                    state_s = state_r;
                end
            end

            ST_LOAD, ST_SHIFT: begin
                // The bit just shifted out of lfsr_r[0] is consumed; advance.
                lfsr_s = lfsr_adv_s;
                busy_s = 1'b1;
                if (state_r == ST_SHIFT) begin
                    misr_s = misr_adv_s;
                end else begin
                    // The chain contents during the first load are unknown.
                    misr_s = misr_r;
                end
                if (last_bit_s) begin
                    state_s     = ST_CAPTURE;
                    shift_cnt_s = {SC_W{1'b0}};
                    scan_en_s   = 1'b0;
                    scan_in_s   = 1'b0;
                end else begin
                    shift_cnt_s = shift_cnt_r + SC_W'(1'b1);
                    scan_en_s   = 1'b1;
                    scan_in_s   = lfsr_adv_s[0];
                end
            end

            ST_CAPTURE: begin
                busy_s      = 1'b1;
                scan_en_s   = 1'b1;
                shift_cnt_s = {SC_W{1'b0}};
                if (pat_cnt_r != PAT_LAST) begin
                    // More patterns to go: the next one is loaded while the
                    // previous response is unloaded.
                    state_s   = ST_SHIFT;
                    pat_cnt_s = pat_cnt_r + PC_W'(1'b1);
                    scan_in_s = lfsr_r[0];
                end else begin
                    state_s   = ST_UNLOAD;
                    scan_in_s = 1'b0;
                end
            end

            ST_UNLOAD: begin
                // LFSR frozen; only the response is compacted.
                misr_s = misr_adv_s;
                if (last_bit_s) begin
                    state_s     = ST_DONE;
                    shift_cnt_s = {SC_W{1'b0}};
                    busy_s      = 1'b0;
                    done_s      = 1'b1;
                    pass_s      = (misr_adv_s == GOLDEN);
                    scan_en_s   = 1'b0;
                end else begin
                    shift_cnt_s = shift_cnt_r + SC_W'(1'b1);
                    busy_s      = 1'b1;
                    scan_en_s   = 1'b1;
                end
                scan_in_s = 1'b0;
            end

            default: begin
                // Unreachable encoding: return to a clean idle state.
                state_s     = ST_IDLE;
                shift_cnt_s = {SC_W{1'b0}};
                pat_cnt_s   = {PC_W{1'b0}};
                lfsr_s      = 16'h0000;
                misr_s      = 16'h0000;
                done_s      = 1'b0;
                pass_s      = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset aborts any run and clears the signature.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            shift_cnt_r <= {SC_W{1'b0}};
            pat_cnt_r   <= {PC_W{1'b0}};
            lfsr_r      <= 16'h0000;
            misr_r      <= 16'h0000;
            scan_in_r   <= 1'b0;
            scan_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_cnt_r <= shift_cnt_s;
            pat_cnt_r   <= pat_cnt_s;
            lfsr_r      <= lfsr_s;
            misr_r      <= misr_s;
            scan_in_r   <= scan_in_s;
            scan_en_r   <= scan_en_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
        end
    end

    assign scan_in   = scan_in_r;
    assign scan_en   = scan_en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign signature = misr_r;
    assign pass      = pass_r;

endmodule
